// File: rtl/seq_divider_p.sv
// Multi-cycle restoring divider, one quotient bit per clock, with signed/unsigned
// operands, divide-by-zero and MIN/-1 overflow flagging, Busy level and Done pulse.
module seq_divider_p #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             St,
  input  logic             Signed_mode,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, ZERO, FIX} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             ovf_reg;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             min_by_neg1;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign dvd_neg     = Signed_mode & Dividend[WIDTH-1];
  assign dvs_neg     = Signed_mode & Divisor[WIDTH-1];
  assign dvd_abs     = dvd_neg ? -Dividend : Dividend;
  assign dvs_abs     = dvs_neg ? -Divisor : Divisor;
  assign min_by_neg1 = Signed_mode && (Dividend == MIN_VAL) && (Divisor == '1);

  // The kept partial remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted value and the trial difference need the extra bit.
  assign shifted = {rem_reg, dvd_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_reg};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg  <= IDLE;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      Quotient   <= '0;
      Remainder  <= '0;
      Overflow   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (St) begin
            Busy <= 1'b1;
            if (Divisor == '0) begin
              dvd_reg   <= Dividend;
              state_reg <= ZERO;
            end else begin
              dvd_reg    <= dvd_abs;
              dvs_reg    <= dvs_abs;
              sign_q_reg <= dvd_neg ^ dvs_neg;
              sign_r_reg <= dvd_neg;
              ovf_reg    <= min_by_neg1;
              rem_reg    <= '0;
              cnt_reg    <= '0;
              state_reg  <= DIV;
            end
          end
        end
        DIV: begin
          // dvd_reg shifts out dividend bits at the top and collects quotient bits at the bottom
          if (!trial[WIDTH]) begin
            rem_reg <= trial[WIDTH-1:0];
            dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= shifted[WIDTH-1:0];
            dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) state_reg <= FIX;
        end
        FIX: begin
          Quotient  <= sign_q_reg ? -dvd_reg : dvd_reg;
          Remainder <= sign_r_reg ? -rem_reg : rem_reg;
          Overflow  <= ovf_reg;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
        ZERO: begin
          Quotient  <= '1;
          Remainder <= dvd_reg;
          Overflow  <= 1'b1;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_p.sv
// Scoreboard bench for seq_divider_p: a 16-bit and an 8-bit instance, expected results
// from plain signed/unsigned arithmetic, checked by per-instance monitors on Done.
module tb_seq_divider_p;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        ovf;
    int          lat;
    int          done_cyc;
  } exp_t;

  logic        Clk;
  logic        Rst_n;
  logic        st16, sm16, ovf16, busy16, done16;
  logic [15:0] a16, b16, q16, r16;
  logic        st8, sm8, ovf8, busy8, done8;
  logic [7:0]  a8, b8, q8, r8;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   free16 = 0;
  int   free8 = 0;
  int   busy_cnt16 = 0;
  int   busy_cnt8 = 0;
  exp_t sb16[$];
  exp_t sb8[$];
  exp_t last16, last8;

  seq_divider_p #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Rst_n(Rst_n), .St(st16), .Signed_mode(sm16),
    .Dividend(a16), .Divisor(b16), .Quotient(q16), .Remainder(r16),
    .Overflow(ovf16), .Busy(busy16), .Done(done16)
  );

  seq_divider_p #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .St(st8), .Signed_mode(sm8),
    .Dividend(a8), .Divisor(b8), .Quotient(q8), .Remainder(r8),
    .Overflow(ovf8), .Busy(busy8), .Done(done8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: truncating signed division of the two's-complement values, or plain unsigned.
  function automatic exp_t model(int w, bit sm, logic [63:0] a, logic [63:0] b);
    exp_t        e;
    longint      sa, sb, qq, rr;
    logic [63:0] mask, minv;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    e.done_cyc = 0;
    if (b == 64'd0) begin
      e.q = mask; e.r = a; e.ovf = 1'b1; e.lat = 1;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (sm && a[w-1]) sa = sa - longint'(64'd1 << w);
      if (sm && b[w-1]) sb = sb - longint'(64'd1 << w);
      qq = sa / sb;
      rr = sa % sb;
      e.q   = 64'(qq) & mask;
      e.r   = 64'(rr) & mask;
      e.ovf = sm && (a == minv) && (b == mask);
      e.lat = w + 1;
    end
    return e;
  endfunction

  // Called just after a falling edge; St is sampled at the next rising edge.
  task automatic go16(bit sm, logic [15:0] a, logic [15:0] b);
    exp_t e;
    e = model(16, sm, {48'd0, a}, {48'd0, b});
    e.done_cyc = cyc + 1 + e.lat;
    sb16.push_back(e);
    free16 = e.done_cyc;
    $display("issue16 sm=%0d %04h / %04h -> q=%04h r=%04h ovf=%0d", sm, a, b, e.q[15:0], e.r[15:0], e.ovf);
    st16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(negedge Clk);
    st16 = 1'b0; sm16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic go8(bit sm, logic [7:0] a, logic [7:0] b);
    exp_t e;
    e = model(8, sm, {56'd0, a}, {56'd0, b});
    e.done_cyc = cyc + 1 + e.lat;
    sb8.push_back(e);
    free8 = e.done_cyc;
    $display("issue8  sm=%0d %02h / %02h -> q=%02h r=%02h ovf=%0d", sm, a, b, e.q[7:0], e.r[7:0], e.ovf);
    st8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(negedge Clk);
    st8 = 1'b0; sm8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!Rst_n) begin
      busy_cnt16 = 0;
      last16.q = '0; last16.r = '0; last16.ovf = 1'b0;
    end else begin
      if (busy16) busy_cnt16++;
      if (done16) begin
        if (sb16.size() == 0) begin
          chk("done16_unexpected", 64'(done16), 64'd0);
        end else begin
          e = sb16.pop_front();
          chk("quot16", 64'(q16), e.q);
          chk("rem16", 64'(r16), e.r);
          chk("ovf16", 64'(ovf16), 64'(e.ovf));
          chk("latency16", 64'(cyc), 64'(e.done_cyc));
          chk("busy_cycles16", 64'(busy_cnt16), 64'(e.lat));
          chk("busy_at_done16", 64'(busy16), 64'd0);
          last16 = e;
        end
        busy_cnt16 = 0;
      end else begin
        chk("hold_quot16", 64'(q16), last16.q);
        chk("hold_rem16", 64'(r16), last16.r);
        chk("hold_ovf16", 64'(ovf16), 64'(last16.ovf));
      end
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (!Rst_n) begin
      busy_cnt8 = 0;
      last8.q = '0; last8.r = '0; last8.ovf = 1'b0;
    end else begin
      if (busy8) busy_cnt8++;
      if (done8) begin
        if (sb8.size() == 0) begin
          chk("done8_unexpected", 64'(done8), 64'd0);
        end else begin
          e = sb8.pop_front();
          chk("quot8", 64'(q8), e.q);
          chk("rem8", 64'(r8), e.r);
          chk("ovf8", 64'(ovf8), 64'(e.ovf));
          chk("latency8", 64'(cyc), 64'(e.done_cyc));
          chk("busy_cycles8", 64'(busy_cnt8), 64'(e.lat));
          last8 = e;
        end
        busy_cnt8 = 0;
      end else begin
        chk("hold_quot8", 64'(q8), last8.q);
        chk("hold_rem8", 64'(r8), last8.r);
      end
    end
  end

  bit          dm[10];
  logic [15:0] da[10];
  logic [15:0] db[10];

  initial begin
    dm = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
    da = '{16'd100, 16'hFFF9, 16'hFFF9, 16'h8000, 16'hFFFF, 16'd1234, 16'd1234, 16'd100, 16'h8000, 16'd0};
    db = '{16'd7, 16'h0002, 16'h0002, 16'hFFFF, 16'h0001, 16'd0, 16'd0, 16'd7, 16'h0001, 16'd9};
    Rst_n = 1'b0;
    st16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    st8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge Clk);
    chk("reset_quot16", 64'(q16), 64'd0);
    chk("reset_rem16", 64'(r16), 64'd0);
    chk("reset_flags16", {61'd0, ovf16, busy16, done16}, 64'd0);
    chk("reset_outs8", {45'd0, q8, r8, ovf8, busy8, done8}, 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 8-bit back-to-back: second St lands in the first Done cycle
    go8(1'b0, 8'd200, 8'd3);
    while (cyc < free8) @(negedge Clk);
    go8(1'b0, 8'd255, 8'd16);

    for (int i = 0; i < 10; i++) begin
      while (cyc < free16) @(negedge Clk);
      go16(dm[i], da[i], db[i]);
    end

    // St while busy must be ignored
    while (cyc < free16) @(negedge Clk);
    go16(1'b0, 16'd5000, 16'd13);
    repeat (5) @(negedge Clk);
    st16 = 1'b1; a16 = 16'd77; b16 = 16'd0;
    @(negedge Clk);
    st16 = 1'b0;

    // Reset at cycle 8 of an operation aborts it with no Done
    while (cyc < free16) @(negedge Clk);
    while (cyc < free8) @(negedge Clk);
    go16(1'b1, 16'hABCD, 16'h0123);
    repeat (7) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("midreset_quot16", 64'(q16), 64'd0);
    chk("midreset_rem16", 64'(r16), 64'd0);
    chk("midreset_flags16", {61'd0, ovf16, busy16, done16}, 64'd0);
    chk("midreset_outs8", {45'd0, q8, r8, ovf8, busy8, done8}, 64'd0);
    sb16.delete();
    free16 = cyc;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (20) @(negedge Clk);
    go16(1'b0, 16'd60000, 16'd7);

    for (int i = 0; i < 60; i++) begin
      bit          sm;
      logic [15:0] a, b;
      while (cyc < free16) @(negedge Clk);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
      sm = 1'($urandom);
      a  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       begin a = 16'h8000; b = 16'hFFFF; end
        default: b = 16'($urandom);
      endcase
      go16(sm, a, b);
    end

    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      while (cyc < free8) @(negedge Clk);
      b = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom);
      go8(1'($urandom), 8'($urandom), b);
    end

    while (cyc < free16 + 3 || cyc < free8 + 3) @(negedge Clk);
    chk("pending16", 64'(sb16.size()), 64'd0);
    chk("pending8", 64'(sb8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
